// File: rtl/bcd_preset_entry.sv
// ---------------------------------------------------------------------------
// bcd_preset_entry : key debounce + two-digit BCD preset editor / run control
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module bcd_preset_entry #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BLINK_CYCLES    = 12500000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       key_sel_n,
   input  logic       key_inc_n,
   input  logic       key_run_n,
   output logic [3:0] preset0,
   output logic [3:0] preset1,
   output logic       load,
   output logic       enable,
   output logic [1:0] blank,
   output logic       editing_tens
);

   localparam int c_DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int c_BLK_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [c_DEB_W-1:0] c_DEB_MAX = c_DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_BLK_W-1:0] c_BLK_MAX = c_BLK_W'(BLINK_CYCLES - 1);

   localparam int c_KEY_SEL = 0;
   localparam int c_KEY_INC = 1;
   localparam int c_KEY_RUN = 2;

   localparam logic [1:0] c_EDIT_UNITS = 2'd0;
   localparam logic [1:0] c_EDIT_TENS  = 2'd1;
   localparam logic [1:0] c_RUN        = 2'd2;

   logic [2:0] w_key_n;
   logic [2:0] w_press;

   assign w_key_n = {key_run_n, key_inc_n, key_sel_n};

   // Each key: 2-FF synchroniser, hold-time filter, falling-edge press detect.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_deb
         logic               r_sync1;
         logic               r_sync2;
         logic               r_stable;
         logic               r_stable_d;
         logic [c_DEB_W-1:0] r_cnt;

         always_ff @(posedge CLOCK_50 or negedge reset) begin
            if (!reset) begin
               r_sync1    <= 1'b1;
               r_sync2    <= 1'b1;
               r_stable   <= 1'b1;
               r_stable_d <= 1'b1;
               r_cnt      <= '0;
            end else begin
               r_sync1    <= w_key_n[gi];
               r_sync2    <= r_sync1;
               r_stable_d <= r_stable;
               if (r_sync2 == r_stable) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_DEB_MAX) begin
                  r_stable <= r_sync2;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end

         assign w_press[gi] = r_stable_d & ~r_stable;
      end
   endgenerate

   logic w_ev_sel;
   logic w_ev_inc;
   logic w_ev_run;

   assign w_ev_sel = w_press[c_KEY_SEL];
   assign w_ev_inc = w_press[c_KEY_INC];
   assign w_ev_run = w_press[c_KEY_RUN];

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [3:0]         r_preset0;
   logic [3:0]         r_preset1;
   logic               r_load;
   logic [c_BLK_W-1:0] r_blink_cnt;
   logic               r_phase;
   logic               w_in_edit;
   logic               w_inc_act;
   logic               w_blink_clr;

   function automatic logic [3:0] bcd_inc(input logic [3:0] d);
      return (d >= 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

   assign w_in_edit   = (r_state == c_EDIT_UNITS) || (r_state == c_EDIT_TENS);
   // run outranks sel outranks inc; losers are dropped, not queued
   assign w_inc_act   = w_in_edit & w_ev_inc & ~w_ev_sel & ~w_ev_run;
   assign w_blink_clr = ~w_in_edit | w_ev_run | w_ev_sel | w_ev_inc;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_state <= c_EDIT_UNITS;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_EDIT_UNITS: begin
            if (w_ev_run)      w_state_next = c_RUN;
            else if (w_ev_sel) w_state_next = c_EDIT_TENS;
         end
         c_EDIT_TENS: begin
            if (w_ev_run)      w_state_next = c_RUN;
            else if (w_ev_sel) w_state_next = c_EDIT_UNITS;
         end
         c_RUN: begin
            if (w_ev_run)      w_state_next = c_EDIT_UNITS;
         end
         default: w_state_next = c_EDIT_UNITS;
      endcase
   end

   always_comb begin
      enable       = 1'b0;
      editing_tens = 1'b0;
      blank        = 2'b00;
      case (r_state)
         c_EDIT_UNITS: blank = {1'b0, r_phase};
         c_EDIT_TENS: begin
            blank        = {r_phase, 1'b0};
            editing_tens = 1'b1;
         end
         c_RUN:   enable = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_preset0 <= 4'd9;
         r_preset1 <= 4'd9;
         r_load    <= 1'b0;
      end else begin
         r_load <= w_in_edit & w_ev_run;
         if (w_inc_act) begin
            if (r_state == c_EDIT_TENS) r_preset1 <= bcd_inc(r_preset1);
            else                        r_preset0 <= bcd_inc(r_preset0);
         end
      end
   end

   // Restarting on every key action keeps the edited digit lit right after it changes.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (w_blink_clr) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (r_blink_cnt == c_BLK_MAX) begin
         r_blink_cnt <= '0;
         r_phase     <= ~r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   assign preset0 = r_preset0;
   assign preset1 = r_preset1;
   assign load    = r_load;

endmodule

`default_nettype wire
